ehgu_clk_gate: RTL and testbench
================================

Name: ehgu_clk_gate

Overview:
- Glitch-free integrated clock gate (ICG) for a single clock domain.
- Passes `clkin` to `clkout` while enabled. Holds `clkout` low while disabled.
- Instantiated at the root of each gateable clock branch.
- Provides:
  - optional enable synchronizer;
  - scan/test bypass;
  - status outputs for observability.

Parameters:
- SYNC_STAGES, 0, flops (clocked on `clkin` rising edge) on `en` before the gating latch. Legal range 0..3; 0 means `en` is already synchronous to `clkin`.
- CNT_W, 16, width of the enabled-cycle counter.

Ports:
- clkin  input  1  free-running source clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  functional clock enable; 1 = clock runs.
- test_en  input  1  scan/test override; 1 forces the clock on.
- clkout  output  1  gated clock.
- en_q  output  1  enable value currently held by the gating latch.
- clk_active  output  1  registered on `clkin` rising edge; 1 when the previous `clkin` cycle produced a `clkout` pulse.
- en_cnt  output  CNT_W  count of `clkin` cycles on which `clkout` pulsed; wraps modulo 2^CNT_W.

Behaviour:
- Effective enable: `en_eff = en_sync | test_en`.
  - `en_sync` is `en` delayed through SYNC_STAGES flops; with SYNC_STAGES=0 it is `en` itself.
  - `test_en` bypasses the synchronizer.
- Gating latch:
  - level-sensitive, transparent while `clkin` is low, holds while `clkin` is high;
  - output is `en_q`;
  - `clkout = clkin & en_q`.
- Glitch freedom: `en_q` changes only while `clkin` is low, so `clkout` never produces a truncated high pulse.
- Latency, SYNC_STAGES=0:
  - `en` changing after `clkin` rising edge N (and settling before the low phase of cycle N) takes effect at rising edge N+1;
  - the first or last full `clkout` pulse coincides with `clkin` cycle N+1.
- Latency, general: SYNC_STAGES additional `clkin` cycles.
- Reset (`rst_n`=0, asynchronous):
  - latch forced to 0 and synchronizer flops cleared, so `clkout`=0 immediately;
  - `en_q`=0, `clk_active`=0, `en_cnt`=0.
- Reset deassertion: the latch resumes on the next `clkin` low phase. The first `clkout` pulse is no earlier than the first `clkin` rising edge after that low phase.
- Reset mid-pulse: `clkout` drops to 0 asynchronously. This is the only permitted truncated pulse.
- `test_en`=1 with `en`=0: `clkout` follows `clkin`; `en_cnt` still counts.
- Both `en` and `test_en` toggling in the same cycle: OR semantics; no priority beyond the OR.
- `clk_active`: flop on `clkin` rising edge capturing `en_q`.
- `en_cnt`:
  - increments on each `clkin` rising edge where `en_q`=1;
  - wraps from all-ones to 0;
  - no saturation.
- `clkout` X-free whenever `rst_n` has been asserted at least once.

Decomposition:
- Shared package `ehgu_clk_pkg`: SYNC_STAGES legal range constant (MAX_SYNC_STAGES=3) and default CNT_W.
- One sub-module `ehgu_clk_sync`: parameterised N-flop synchronizer with async active-low clear, SYNC_STAGES=0 pass-through.
- The gating latch and AND stay in the top. They must be coded so synthesis maps them to the library ICG cell.
- The bench clock source is `thee_clk_gen_module`, a free-running generator driving `clkin`. It is not part of this block.

Test Plan:
- Reset then ungate: `rst_n`=0 for 2 cycles, release, set `en`=1 after a rising edge, wait 2 cycles, then fork-count 3 `clkin` and 3 `clkout` rising edges -> `clkout` count > 0 (expect 3); `en_q`=1; `clk_active`=1.
- Gate: set `en`=0 after a rising edge, wait 2 cycles, count over 3 `clkin` edges -> 0 `clkout` edges; `clkout` stays 0; `en_q`=0; `clk_active`=0.
- Re-ungate after gate: `en`=1 -> `clkout` resumes within 1 cycle (SYNC_STAGES=0) with full-width high pulses; no pulse shorter than `clkin` high time.
- Glitch check: toggle `en` mid-high-phase of `clkin` -> `clkout` unchanged until the following low phase; no runt pulse.
- Test bypass: `en`=0, `test_en`=1 for 5 cycles -> 5 `clkout` pulses; `en_cnt` advances by 5. `test_en`=0 -> `clkout` low from the next cycle.
- Counter wrap and reset: CNT_W=4, `en`=1 for 17 cycles -> `en_cnt`=1. Assert `rst_n`=0 mid-high-phase -> `clkout` and `en_cnt` go to 0 immediately.
- Synchronizer latency: SYNC_STAGES=2, `en` 0->1 after edge N -> first `clkout` pulse at edge N+3.

Source files
------------

// File: rtl/ehgu_clk_pkg.sv
// Shared constants for the ehgu clock-gate slice: synchronizer depth limit,
// default counter width and a helper that keeps the synchronizer depth legal.
package ehgu_clk_pkg;

  localparam int MAX_SYNC_STAGES = 3;
  localparam int DEF_CNT_W       = 16;

  // Limit a requested synchronizer depth to the supported 0..MAX_SYNC_STAGES range
  function automatic int sync_stages_clamp(input int n);
    int r;
    if (n < 0) begin
      r = 0;
    end else if (n > MAX_SYNC_STAGES) begin
      r = MAX_SYNC_STAGES;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/ehgu_clk_sync.sv
// N-flop enable synchronizer with asynchronous active-low clear.
// STAGES=0 degenerates to a wire for enables already synchronous to clk.
module ehgu_clk_sync
  import ehgu_clk_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  generate
    if (STAGES == 0) begin : g_bypass
      // clk/rst_n are intentionally unused when there is nothing to register
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst_n};
      assign dout     = din;
    end else begin : g_sync
      logic [STAGES-1:0] sync_d;
      logic [STAGES-1:0] sync_q;

      // Shift din one stage deeper per clk edge
      always_comb begin
        sync_d    = {STAGES{1'b0}};
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchronizer state register, cleared by reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= {STAGES{1'b0}};
        end else begin
          sync_q <= sync_d;
        end
      end

      assign dout = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ehgu_clk_gate.sv
// Glitch-free latch-based integrated clock gate with optional enable
// synchronizer, scan bypass and enabled-cycle observability counters.
module ehgu_clk_gate
  import ehgu_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             test_en,
  output logic             clkout,
  output logic             en_q,
  output logic             clk_active,
  output logic [CNT_W-1:0] en_cnt
);

  localparam int SYNC_N = sync_stages_clamp(SYNC_STAGES);

  logic             en_sync_s;
  logic             en_eff_s;
  logic             en_lat_s;
  logic             clk_active_d;
  logic             clk_active_q;
  logic [CNT_W-1:0] en_cnt_d;
  logic [CNT_W-1:0] en_cnt_q;

  ehgu_clk_sync #(
    .STAGES (SYNC_N)
  ) u_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .din   (en),
    .dout  (en_sync_s)
  );

  // test_en skips the synchronizer so scan can force the clock on directly
  assign en_eff_s = en_sync_s | test_en;

  // Low-transparent latch + AND: the canonical ICG pattern, kept together so
  // synthesis maps it onto the library clock-gate cell.
  always_latch begin
    if (!rst_n) begin
      en_lat_s = 1'b0;
    end else if (!clkin) begin
      en_lat_s = en_eff_s;
    end
  end

  assign clkout = clkin & en_lat_s;
  assign en_q   = en_lat_s;

  // Next-state for the activity flag and the enabled-cycle counter
  always_comb begin
    clk_active_d = en_lat_s;
    if (en_lat_s) begin
      en_cnt_d = en_cnt_q + CNT_W'(1'b1);
    end else begin
      en_cnt_d = en_cnt_q;
    end
  end

  // Observability registers, sampled on the source clock
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      clk_active_q <= 1'b0;
      en_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      clk_active_q <= clk_active_d;
      en_cnt_q     <= en_cnt_d;
    end
  end

  assign clk_active = clk_active_q;
  assign en_cnt     = en_cnt_q;

endmodule

// File: tb/tb_ehgu_clk_gate.sv
// Directed self-checking bench for ehgu_clk_gate: three instances cover the
// default build, a 4-bit counter build and a 2-stage synchronizer build.
module tb_ehgu_clk_gate;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        en0 = 1'b0, test_en0 = 1'b0;
  logic        en4 = 1'b0, en2 = 1'b0, te_off = 1'b0;
  logic        clkout0, en_q0, clk_active0;
  logic [15:0] en_cnt0;
  logic        clkout4, en_q4, clk_active4;
  logic [3:0]  en_cnt4;
  logic        clkout2, en_q2, clk_active2;
  logic [15:0] en_cnt2;

  int  checks = 0;
  int  failures = 0;
  int  cnt_out0 = 0;
  int  cnt_clk = 0;
  int  runt0 = 0;
  bit  seen_rise0 = 1'b0;
  time rise_t0 = 0;
  int  exp_cnt0 = 0;

  ehgu_clk_gate #(.SYNC_STAGES(0), .CNT_W(16)) u_dut0 (
    .clkin(clkin), .rst_n(rst_n), .en(en0), .test_en(test_en0),
    .clkout(clkout0), .en_q(en_q0), .clk_active(clk_active0), .en_cnt(en_cnt0));

  ehgu_clk_gate #(.SYNC_STAGES(0), .CNT_W(4)) u_dut4 (
    .clkin(clkin), .rst_n(rst_n), .en(en4), .test_en(te_off),
    .clkout(clkout4), .en_q(en_q4), .clk_active(clk_active4), .en_cnt(en_cnt4));

  ehgu_clk_gate #(.SYNC_STAGES(2), .CNT_W(16)) u_dut2 (
    .clkin(clkin), .rst_n(rst_n), .en(en2), .test_en(te_off),
    .clkout(clkout2), .en_q(en_q2), .clk_active(clk_active2), .en_cnt(en_cnt2));

  always #5 clkin = ~clkin;

  always @(posedge clkin) cnt_clk++;

  always @(posedge clkout0) begin
    cnt_out0++;
    rise_t0    = $time;
    seen_rise0 = 1'b1;
  end

  // Any high pulse shorter than the clkin high time is a runt, unless reset cut it
  always @(negedge clkout0) begin
    if (rst_n && seen_rise0 && (($time - rise_t0) < 5)) runt0++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (2) @(posedge clkin);
    #1;
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL reset_clkout got=%b exp=0", clkout0); end
    checks++; if (en_q0 !== 1'b0) begin failures++; $display("FAIL reset_en_q got=%b exp=0", en_q0); end
    checks++; if (clk_active0 !== 1'b0) begin failures++; $display("FAIL reset_clk_active got=%b exp=0", clk_active0); end
    checks++; if (en_cnt0 !== 16'd0) begin failures++; $display("FAIL reset_en_cnt got=%0d exp=0", en_cnt0); end
    rst_n = 1'b1;
  endtask

  task automatic test_ungate();
    int b_out, b_clk;
    @(posedge clkin); #1 en0 = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    exp_cnt0 = 2;
    b_out = cnt_out0; b_clk = cnt_clk;
    fork
      repeat (3) @(posedge clkin);
      repeat (3) @(posedge clkout0);
    join
    #1;
    exp_cnt0 += 3;
    checks++; if (cnt_clk - b_clk !== 3) begin failures++; $display("FAIL ungate_clkin_edges got=%0d exp=3", cnt_clk - b_clk); end
    checks++; if (cnt_out0 - b_out !== 3) begin failures++; $display("FAIL ungate_clkout_edges got=%0d exp=3", cnt_out0 - b_out); end
    checks++; if (en_q0 !== 1'b1) begin failures++; $display("FAIL ungate_en_q got=%b exp=1", en_q0); end
    checks++; if (clk_active0 !== 1'b1) begin failures++; $display("FAIL ungate_clk_active got=%b exp=1", clk_active0); end
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL ungate_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
  endtask

  task automatic test_gate();
    int b_out;
    @(posedge clkin); #1 en0 = 1'b0;
    exp_cnt0 += 1;
    repeat (2) @(posedge clkin);
    #1;
    b_out = cnt_out0;
    repeat (3) @(posedge clkin);
    #1;
    checks++; if (cnt_out0 - b_out !== 0) begin failures++; $display("FAIL gate_clkout_edges got=%0d exp=0", cnt_out0 - b_out); end
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL gate_clkout_low got=%b exp=0", clkout0); end
    checks++; if (en_q0 !== 1'b0) begin failures++; $display("FAIL gate_en_q got=%b exp=0", en_q0); end
    checks++; if (clk_active0 !== 1'b0) begin failures++; $display("FAIL gate_clk_active got=%b exp=0", clk_active0); end
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL gate_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
  endtask

  task automatic test_reungate();
    @(posedge clkin); #1 en0 = 1'b1;
    checks++; if (en_q0 !== 1'b0) begin failures++; $display("FAIL reungate_hold_high got=%b exp=0", en_q0); end
    @(negedge clkin); #1;
    checks++; if (en_q0 !== 1'b1) begin failures++; $display("FAIL reungate_latch_open got=%b exp=1", en_q0); end
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL reungate_low_phase got=%b exp=0", clkout0); end
    @(posedge clkin); #1;
    checks++; if (clkout0 !== 1'b1) begin failures++; $display("FAIL reungate_first_pulse got=%b exp=1", clkout0); end
    repeat (2) @(posedge clkin);
    #1;
    exp_cnt0 += 3;
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL reungate_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
  endtask

  task automatic test_glitch();
    en0 = 1'b0;
    #2;
    checks++; if (clkout0 !== 1'b1) begin failures++; $display("FAIL glitch_fall_held got=%b exp=1", clkout0); end
    checks++; if (en_q0 !== 1'b1) begin failures++; $display("FAIL glitch_en_q_held got=%b exp=1", en_q0); end
    @(negedge clkin); #1;
    checks++; if (en_q0 !== 1'b0) begin failures++; $display("FAIL glitch_latch_low got=%b exp=0", en_q0); end
    @(posedge clkin); #1 en0 = 1'b1;
    #1;
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL glitch_rise_held got=%b exp=0", clkout0); end
    @(posedge clkin); #1;
    exp_cnt0 += 1;
    checks++; if (clkout0 !== 1'b1) begin failures++; $display("FAIL glitch_resume got=%b exp=1", clkout0); end
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL glitch_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
    en0 = 1'b0;
  endtask

  task automatic test_bypass();
    int b_out;
    @(posedge clkin); #1 test_en0 = 1'b1;
    b_out = cnt_out0;
    repeat (5) @(posedge clkin);
    #1 test_en0 = 1'b0;
    exp_cnt0 += 5;
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL bypass_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
    @(posedge clkin); #1;
    checks++; if (cnt_out0 - b_out !== 5) begin failures++; $display("FAIL bypass_pulses got=%0d exp=5", cnt_out0 - b_out); end
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL bypass_off got=%b exp=0", clkout0); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vec [4];
    logic       exp_out [4];
    vec[0] = 2'b11; exp_out[0] = 1'b0;
    vec[1] = 2'b01; exp_out[1] = 1'b1;
    vec[2] = 2'b10; exp_out[2] = 1'b1;
    vec[3] = 2'b00; exp_out[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clkin); #1;
      checks++; if (clkout0 !== exp_out[i]) begin failures++; $display("FAIL b2b_clkout[%0d] got=%b exp=%b", i, clkout0, exp_out[i]); end
      {en0, test_en0} = vec[i];
    end
    @(posedge clkin); #1;
    exp_cnt0 += 3;
    checks++; if (clkout0 !== 1'b0) begin failures++; $display("FAIL b2b_final_off got=%b exp=0", clkout0); end
    checks++; if (en_cnt0 !== 16'(exp_cnt0)) begin failures++; $display("FAIL b2b_en_cnt got=%0d exp=%0d", en_cnt0, exp_cnt0); end
  endtask

  task automatic test_sync2();
    @(posedge clkin); #1 en2 = 1'b1;
    @(posedge clkin); #1;
    checks++; if (clkout2 !== 1'b0) begin failures++; $display("FAIL sync2_edge_n1 got=%b exp=0", clkout2); end
    @(posedge clkin); #1;
    checks++; if (clkout2 !== 1'b0) begin failures++; $display("FAIL sync2_edge_n2 got=%b exp=0", clkout2); end
    checks++; if (en_q2 !== 1'b0) begin failures++; $display("FAIL sync2_en_q_n2 got=%b exp=0", en_q2); end
    @(negedge clkin); #1;
    checks++; if (en_q2 !== 1'b1) begin failures++; $display("FAIL sync2_latch got=%b exp=1", en_q2); end
    @(posedge clkin); #1;
    checks++; if (clkout2 !== 1'b1) begin failures++; $display("FAIL sync2_edge_n3 got=%b exp=1", clkout2); end
    checks++; if (en_cnt2 !== 16'd1) begin failures++; $display("FAIL sync2_en_cnt got=%0d exp=1", en_cnt2); end
    en2 = 1'b0;
  endtask

  task automatic test_wrap_reset();
    @(posedge clkin); #1 en4 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clkin); #1;
      if (i == 15) begin
        checks++; if (en_cnt4 !== 4'hF) begin failures++; $display("FAIL wrap_all_ones got=%0d exp=15", en_cnt4); end
      end else if (i == 16) begin
        checks++; if (en_cnt4 !== 4'h0) begin failures++; $display("FAIL wrap_to_zero got=%0d exp=0", en_cnt4); end
      end else if (i == 17) begin
        checks++; if (en_cnt4 !== 4'h1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", en_cnt4); end
      end
    end
    checks++; if (clkout4 !== 1'b1) begin failures++; $display("FAIL wrap_pulse_high got=%b exp=1", clkout4); end
    rst_n = 1'b0;
    #1;
    checks++; if (clkout4 !== 1'b0) begin failures++; $display("FAIL rst_mid_clkout got=%b exp=0", clkout4); end
    checks++; if (en_cnt4 !== 4'h0) begin failures++; $display("FAIL rst_mid_en_cnt got=%0d exp=0", en_cnt4); end
    checks++; if (en_q4 !== 1'b0) begin failures++; $display("FAIL rst_mid_en_q got=%b exp=0", en_q4); end
    checks++; if (clk_active4 !== 1'b0) begin failures++; $display("FAIL rst_mid_clk_active got=%b exp=0", clk_active4); end
    en4 = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ungate();
    test_gate();
    test_reungate();
    test_glitch();
    test_bypass();
    test_back_to_back();
    test_sync2();
    test_wrap_reset();
    repeat (2) @(posedge clkin);
    #1;
    checks++; if (runt0 !== 0) begin failures++; $display("FAIL runt_pulses got=%0d exp=0", runt0); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
